// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: fetch/decode FSM that owns the PC and issues one-cycle
// control strobes to the accumulator/ALU datapath and data RAM, halting on HLT.
module bip_control_unit #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    output logic [ADDR_W-1:0] OPERAND,
    output logic [1:0]        SEL_A,
    output logic              SEL_B,
    output logic              ALU_OP,
    output logic              WR_ACC,
    output logic              WR_RAM,
    output logic              RD_RAM,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  CYCLE_COUNT
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEMRD, EXEC, HALT} state_t;

    // Control word for the EXEC cycle; set_* flags mark selects the opcode defines.
    typedef struct packed {
        logic       wr_acc;
        logic       wr_ram;
        logic       illegal;
        logic       set_a;
        logic [1:0] sel_a;
        logic       set_alu;
        logic       sel_b;
        logic       alu_op;
    } exec_t;

    function automatic exec_t decode_exec(input logic [4:0] op);
        exec_t c;
        c = '0;
        case (op)
            OP_HLT: ;
            OP_STO: c.wr_ram = 1'b1;
            OP_LD: begin
                c.set_a  = 1'b1;
                c.sel_a  = 2'b00;
                c.wr_acc = 1'b1;
            end
            OP_LDI: begin
                c.set_a  = 1'b1;
                c.sel_a  = 2'b01;
                c.wr_acc = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                c.set_a   = 1'b1;
                c.sel_a   = 2'b10;
                c.set_alu = 1'b1;
                c.sel_b   = op[0];
                c.alu_op  = (op == OP_SUB) || (op == OP_SUBI);
                c.wr_acc  = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        ir_op;
    logic [4:0]        dec_op;
    logic              is_mem;
    logic              enter_exec;
    exec_t             ctl;

    assign PROG_ADDR = pc;

    // NOTE: always_comb assigns every output on every path, so no latches are inferred.
    always_comb begin
        dec_op     = PROG_DATA[DATA_W-1 -: 5];
        is_mem     = (dec_op == OP_LD) || (dec_op == OP_ADD) || (dec_op == OP_SUB);
        ctl        = decode_exec((state == MEMRD) ? ir_op : dec_op);
        enter_exec = (state == MEMRD) ||
                     ((state == DECODE) && (dec_op != OP_HLT) && !is_mem);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            pc          <= '0;
            ir_op       <= '0;
            CYCLE_COUNT <= '0;
            OPERAND     <= '0;
            SEL_A       <= 2'b00;
            SEL_B       <= 1'b0;
            ALU_OP      <= 1'b0;
            WR_ACC      <= 1'b0;
            WR_RAM      <= 1'b0;
            RD_RAM      <= 1'b0;
            HALTED      <= 1'b0;
            ILLEGAL     <= 1'b0;
        end else begin
            WR_ACC <= 1'b0;
            WR_RAM <= 1'b0;
            RD_RAM <= 1'b0;

            if (state inside {FETCH, DECODE, MEMRD, EXEC} && CYCLE_COUNT != '1)
                CYCLE_COUNT <= CYCLE_COUNT + 1'b1;

            case (state)
                IDLE:   if (START) state <= FETCH;
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir_op   <= dec_op;
                    OPERAND <= PROG_DATA[ADDR_W-1:0];
                    if (dec_op == OP_HLT) begin
                        state  <= HALT;
                        HALTED <= 1'b1;
                    end else if (is_mem) begin
                        state  <= MEMRD;
                        RD_RAM <= 1'b1;
                    end else begin
                        state  <= EXEC;
                    end
                end
                MEMRD:  state <= EXEC;
                EXEC: begin
                    pc    <= pc + 1'b1;
                    state <= FETCH;
                end
                HALT:    ;
                default: state <= IDLE;
            endcase

            // Strobes land in the EXEC cycle; selects hold unless the opcode defines them.
            if (enter_exec) begin
                WR_ACC <= ctl.wr_acc;
                WR_RAM <= ctl.wr_ram;
                if (ctl.illegal) ILLEGAL <= 1'b1;
                if (ctl.set_a)   SEL_A   <= ctl.sel_a;
                if (ctl.set_alu) begin
                    SEL_B  <= ctl.sel_b;
                    ALU_OP <= ctl.alu_op;
                end
            end
        end
    end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Instruction sequencer for the BIP processor. Owns the program counter and drives the program memory address (11-bit address, 16-bit word, one-cycle registered read).
- Fetches and decodes each instruction (opcode [15:11], operand [10:0]) and issues one-cycle control strobes to the accumulator/ALU datapath and data RAM.
- Stops on HLT and counts executed clock cycles.

Parameters:
- ADDR_W, 11, program/data address and operand width
- DATA_W, 16, instruction word width
- CNT_W, 16, cycle counter width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  level; begin execution from IDLE
- PROG_ADDR  out  ADDR_W  program memory address (= PC)
- PROG_DATA  in  DATA_W  program memory read data, valid one cycle after PROG_ADDR
- OPERAND  out  ADDR_W  decoded operand field (data RAM address or immediate)
- SEL_A  out  2  accumulator source: 00 data RAM, 01 immediate, 10 ALU result
- SEL_B  out  1  ALU B source: 0 data RAM, 1 immediate
- ALU_OP  out  1  0 add, 1 subtract
- WR_ACC  out  1  accumulator write strobe
- WR_RAM  out  1  data RAM write strobe (accumulator -> RAM[OPERAND])
- RD_RAM  out  1  data RAM read enable
- HALTED  out  1  HLT executed
- ILLEGAL  out  1  sticky; an undefined opcode was decoded
- CYCLE_COUNT  out  CNT_W  clock cycles spent outside IDLE/HALT

Behaviour:
- Reset (synchronous, CLK edge with RESET=1) forces:
  - state IDLE, PC=0, IR=0, CYCLE_COUNT=0
  - all strobes (WR_ACC, WR_RAM, RD_RAM) = 0
  - HALTED=0, ILLEGAL=0, SEL_A=00, SEL_B=0, ALU_OP=0, OPERAND=0
  - RESET overrides every other input in any state, including mid-instruction.
- PROG_ADDR = PC at all times (registered PC, no combinational path from PROG_DATA).
- States: IDLE, FETCH, DECODE, MEMRD, EXEC, HALT.
  - IDLE: wait; START=1 -> FETCH. START is ignored in all other states.
  - FETCH: PC presented; memory registers the word at this edge -> DECODE.
  - DECODE: IR <= PROG_DATA; OPERAND <= PROG_DATA[10:0].
    - Opcode 00010 LD, 00100 ADD, 00110 SUB -> MEMRD.
    - Opcode 00000 HLT -> HALT.
    - All others -> EXEC.
  - MEMRD: RD_RAM=1 for exactly one cycle -> EXEC.
  - EXEC: exactly one cycle of strobes per opcode, then PC <= PC+1 -> FETCH:
    - 00001 STO: WR_RAM=1
    - 00010 LD: SEL_A=00, WR_ACC=1
    - 00011 LDI: SEL_A=01, WR_ACC=1
    - 00100 ADD: SEL_A=10, SEL_B=0, ALU_OP=0, WR_ACC=1
    - 00101 ADDI: SEL_A=10, SEL_B=1, ALU_OP=0, WR_ACC=1
    - 00110 SUB: SEL_A=10, SEL_B=0, ALU_OP=1, WR_ACC=1
    - 00111 SUBI: SEL_A=10, SEL_B=1, ALU_OP=1, WR_ACC=1
    - 01000..11111: no strobes (NOP), ILLEGAL <= 1 (sticky until RESET).
  - HALT: HALTED=1, all strobes 0, PC frozen at the HLT address; exit only by RESET.
- Strobes are zero in every state except as listed; SEL_A/SEL_B/ALU_OP hold their last value outside EXEC.
- Latency: 3 cycles per immediate/STO instruction, 4 per LD/ADD/SUB, 2 to reach HALT after FETCH of HLT.
- PC wraps 2047 -> 0 with no flag.
- CYCLE_COUNT increments every cycle in FETCH/DECODE/MEMRD/EXEC. It saturates at 2^CNT_W-1 and is frozen in IDLE and HALT.

Test Plan:
- RESET 1 cycle, START=0 for 5 cycles -> state IDLE, PROG_ADDR=0, all strobes 0, CYCLE_COUNT=0.
- Program [STO 1, LDI 0, ADDI 4, HLT], START pulse:
  - WR_RAM at cycle 3 with OPERAND=1.
  - WR_ACC+SEL_A=01 at cycle 6.
  - WR_ACC+SEL_A=10+SEL_B=1+ALU_OP=0 with OPERAND=4 at cycle 9.
  - HALTED=1, PROG_ADDR=3, CYCLE_COUNT=11.
- Program [LD 5, SUB 6, HLT]:
  - RD_RAM one cycle before each WR_ACC.
  - SUB EXEC shows SEL_B=0, ALU_OP=1.
  - Each memory instruction takes 4 cycles.
- Opcode 11111 at addr 0, then HLT -> no strobes in the first EXEC, ILLEGAL=1 stays set after HALT, PC advances to 1.
- RESET asserted during MEMRD of an ADD -> next cycle IDLE, RD_RAM=0, PC=0, CYCLE_COUNT=0, ILLEGAL=0. START then restarts from address 0.
- PC preloaded by executing 2047 NOP-class (LDI) words -> PROG_ADDR wraps to 0 after the word at address 2047.
